timebase_gen: RTL and testbench
===============================

Name: timebase_gen

Overview:
- Parametrised successor to the fixed 1 ms tick divider.
- Generates a base tick from clk using a runtime-loadable divisor.
- Cascades the base tick into NUM_CASC slower ticks; for example 1 ms, 10 ms, 100 ms and 1 s at a 100 MHz clk.
- Keeps a free-running elapsed-tick counter with wrap or saturate mode. Feeds the game's timing FSM and display refresh logic.

Parameters:
DIV_W, 17, width of prescaler and divisor registers
DEFAULT_DIV, 100000, divisor loaded at reset (base tick period in clk cycles)
NUM_CASC, 3, number of cascaded stages above the base tick
CASC_RATIO, 10, division ratio of each cascaded stage (>=2)
CNT_W, 16, width of elapsed-tick counter
SATURATE, 0, 0 = counter wraps, 1 = counter saturates at all-ones

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  1  count enable; low freezes all counters
clr  in  1  synchronous clear of all counters and flags
div_load  in  1  one-cycle strobe: capture div_value as pending divisor
div_value  in  DIV_W  new divisor; values <2 clamped to 2
load_pending  out  1  high while a captured divisor awaits application
tick  out  NUM_CASC+1  tick[0] is the base tick; tick[k] fires once every CASC_RATIO^k base ticks; registered single-cycle pulses
elapsed  out  CNT_W  number of base ticks since reset or clr
ovf  out  1  sticky: elapsed wrapped (SATURATE=0) or hit max (SATURATE=1)

Behaviour:
- Reset values: prescaler=0, div_active=DEFAULT_DIV, shadow=0, load_pending=0, all cascade counters=0, tick=0, elapsed=0, ovf=0.
- Prescaler and base tick:
  - When en=1, the prescaler counts 0..div_active-1, then wraps to 0.
  - The terminal cycle (prescaler==div_active-1 with en=1) is the internal strobe s0.
  - tick[0] goes high for exactly one cycle, the cycle after s0.
  - First tick[0] after reset appears div_active cycles after the first enabled edge. Period is exactly div_active cycles.
- Cascade:
  - Stage k (1..NUM_CASC) has a counter 0..CASC_RATIO-1 that advances on strobe s(k-1).
  - s(k) = s(k-1) AND (stage k counter == CASC_RATIO-1).
  - All tick bits are registered from their strobes in the same cycle, so tick[k] is always coincident with a tick[0] pulse. No extra per-stage latency.
- en=0:
  - Prescaler, cascade counters and elapsed hold their values.
  - All tick bits are 0 on the following cycle.
  - Resuming continues from the held count with no lost or duplicate tick.
- clr (synchronous, priority over en and div_load):
  - Next cycle: prescaler, cascade counters and elapsed = 0; tick = 0; ovf = 0.
  - If load_pending=1, the shadow is copied to div_active and load_pending is cleared.
  - A div_load in the same cycle as clr is discarded.
- Divisor load:
  - div_load captures max(div_value,2) into the shadow and sets load_pending the next cycle.
  - The shadow is applied at the next s0: div_active is updated on the same edge the prescaler wraps, so the following period uses the new divisor. load_pending clears on that edge.
  - If div_load coincides with s0, the new value is applied at that wrap; load_pending never asserts.
  - A second div_load while pending overwrites the shadow; only the last value is applied.
  - The current period is never truncated.
- Elapsed counter:
  - Increments on each s0.
  - At all-ones with SATURATE=0: wraps to 0 and sets ovf.
  - At all-ones with SATURATE=1: holds all-ones and sets ovf.
  - ovf clears only on rst or clr.
- Widths and elaboration checks:
  - Arithmetic is unsigned. Cascade counter width = clog2(CASC_RATIO).
  - DEFAULT_DIV must fit in DIV_W and be >=2.
  - CASC_RATIO must be >=2.
  - Both are elaboration-time checks.
- Async rst mid-period: all state returns to reset values immediately, including div_active=DEFAULT_DIV; any pending load is lost.

Decomposition:
- Shared package timebase_pkg holds:
  - DEFAULT_DIV_1MS_100MHZ = 100000
  - DECADE = 10
  - the clamp minimum DIV_MIN = 2
  - the SAT/WRAP mode constants
- One natural sub-module: tb_casc_stage.
  - Ports: clk, rst, en, clr, strobe_in; outputs strobe_out and count.
  - Generated NUM_CASC times in a chain.

Test Plan:
- DEFAULT_DIV=4, CASC_RATIO=3, NUM_CASC=2, en=1 from reset release:
  - tick[0] at cycles 4,8,12,…; tick[1] at cycles 12,24; tick[2] at cycle 36, coincident with tick[0] and tick[1].
  - elapsed=9 after cycle 36.
- div_load with value 6 at prescaler=1 (div_active=4):
  - load_pending=1 until the wrap; that period still lasts 4 cycles.
  - Subsequent tick[0] spacing is 6. Repeat with div_load coincident with s0: load_pending stays 0.
- div_value=0 and 1: both clamped, giving tick[0] every 2 cycles. Back-to-back loads 5 then 7 while pending: only 7 is applied.
- en low for 10 cycles at prescaler=2: no ticks during the low period. After en rises, next tick[0] appears 2 cycles later; elapsed is unchanged during the pause.
- clr while elapsed=7, ovf=1 and a load is pending:
  - Next cycle: elapsed=0, ovf=0, tick=0, load_pending=0.
  - Same-cycle div_load is ignored.
- CNT_W=3:
  - SATURATE=0: after 8 base ticks, elapsed=0 and ovf=1.
  - SATURATE=1: elapsed holds 7 and ovf=1.
  - Assert async rst mid-period: outputs zero immediately and div_active returns to 4.

Source files
------------

// File: rtl/timebase_pkg.sv
// Shared constants for the timebase generator and its cascade stages.
//   DEFAULT_DIV_1MS_100MHZ : base tick divisor giving 1 ms at 100 MHz
//   DECADE                 : default cascade ratio (1 ms -> 10 ms -> ...)
//   DIV_MIN                : smallest divisor accepted; smaller loads are clamped
//   MODE_WRAP / MODE_SAT   : elapsed-counter overflow behaviour
package timebase_pkg;

   localparam int unsigned DEFAULT_DIV_1MS_100MHZ = 100000;
   localparam int unsigned DECADE                 = 10;
   localparam int unsigned DIV_MIN                = 2;

   localparam bit MODE_WRAP = 1'b0;
   localparam bit MODE_SAT  = 1'b1;

endpackage

// File: rtl/tb_casc_stage.sv
// One cascade stage of the timebase: a 0..RATIO-1 counter advanced by the
// strobe of the previous stage. Passes the strobe on when it is at terminal.
//   clk, rst    : clock, async active-high reset
//   en          : count enable
//   clr         : synchronous clear of the counter
//   strobe_in   : strobe of the previous (faster) stage
//   strobe_out  : strobe_in qualified by this stage's terminal count
//   count       : current stage count
module tb_casc_stage
   import timebase_pkg::*;
#(
   parameter int unsigned RATIO = DECADE
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       clr,
   input  logic                       strobe_in,
   output logic                       strobe_out,
   output logic [$clog2(RATIO)-1:0]   count
);

   localparam int unsigned CW = $clog2(RATIO);

   logic at_max;

   assign at_max     = (count == CW'(RATIO - 1));
   assign strobe_out = en & strobe_in & at_max;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && strobe_in) begin
         count <= at_max ? '0 : count + CW'(1);
      end
   end

endmodule

// File: rtl/timebase_gen.sv
// Programmable timebase: a base tick from clk with a runtime-loadable
// divisor, NUM_CASC cascaded slower ticks, and an elapsed base-tick counter.
//   clk, rst      : clock, async active-high reset
//   en            : count enable; low freezes all counters
//   clr           : synchronous clear of counters and flags
//   div_load      : strobe capturing div_value (clamped to >= 2) as pending divisor
//   div_value     : new divisor
//   load_pending  : a captured divisor waits for the next base-period wrap
//   tick          : registered single-cycle pulses; tick[k] every CASC_RATIO^k base ticks
//   elapsed       : base ticks since reset or clr
//   ovf           : sticky wrap/saturate indication
module timebase_gen
   import timebase_pkg::*;
#(
   parameter int unsigned DIV_W       = 17,
   parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_1MS_100MHZ,
   parameter int unsigned NUM_CASC    = 3,
   parameter int unsigned CASC_RATIO  = DECADE,
   parameter int unsigned CNT_W       = 16,
   parameter bit          SATURATE    = MODE_WRAP
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clr,
   input  logic                div_load,
   input  logic [DIV_W-1:0]    div_value,
   output logic                load_pending,
   output logic [NUM_CASC:0]   tick,
   output logic [CNT_W-1:0]    elapsed,
   output logic                ovf
);

   localparam int unsigned CW = $clog2(CASC_RATIO);

   if (CASC_RATIO < 2) begin : g_bad_ratio
      $error("timebase_gen: CASC_RATIO must be >= 2");
   end
   if ((DEFAULT_DIV < DIV_MIN) || ((DEFAULT_DIV >> DIV_W) != 0)) begin : g_bad_div
      $error("timebase_gen: DEFAULT_DIV must be >= 2 and fit in DIV_W bits");
   end

   logic [DIV_W-1:0]       prescaler;
   logic [DIV_W-1:0]       div_active;
   logic [DIV_W-1:0]       shadow;
   logic [DIV_W-1:0]       div_clamped;
   logic [NUM_CASC:0]      strobe;
   logic [NUM_CASC*CW-1:0] casc_count;
   logic                   unused_casc;

   assign div_clamped = (div_value < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : div_value;
   assign strobe[0]   = en & (prescaler == div_active - DIV_W'(1));

   // Stage counts are only kept for debug visibility.
   assign unused_casc = ^casc_count;

   for (genvar k = 1; k <= NUM_CASC; k++) begin : g_casc
      tb_casc_stage #(
         .RATIO      (CASC_RATIO)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .en         (en),
         .clr        (clr),
         .strobe_in  (strobe[k-1]),
         .strobe_out (strobe[k]),
         .count      (casc_count[(k-1)*CW +: CW])
      );
   end

   // Prescaler and divisor handover. A new divisor only takes effect on the
   // wrap edge, so the running period is never cut short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescaler    <= '0;
         div_active   <= DIV_W'(DEFAULT_DIV);
         shadow       <= '0;
         load_pending <= 1'b0;
      end else if (clr) begin
         prescaler <= '0;
         if (load_pending) begin
            div_active   <= shadow;
            load_pending <= 1'b0;
         end
      end else begin
         if (en) begin
            prescaler <= strobe[0] ? '0 : prescaler + DIV_W'(1);
         end
         if (strobe[0]) begin
            if (div_load) begin
               shadow     <= div_clamped;
               div_active <= div_clamped;
            end else if (load_pending) begin
               div_active <= shadow;
            end
            load_pending <= 1'b0;
         end else if (div_load) begin
            shadow       <= div_clamped;
            load_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick    <= '0;
         elapsed <= '0;
         ovf     <= 1'b0;
      end else if (clr) begin
         tick    <= '0;
         elapsed <= '0;
         ovf     <= 1'b0;
      end else begin
         tick <= strobe;
         if (strobe[0]) begin
            if (elapsed == {CNT_W{1'b1}}) begin
               ovf <= 1'b1;
               if (SATURATE == MODE_WRAP) begin
                  elapsed <= '0;
               end
            end else begin
               elapsed <= elapsed + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_timebase_gen.sv
module tb_timebase_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic        clr;
   logic        div_load;
   logic [16:0] div_value;

   logic        pend_a, pend_w, pend_s;
   logic [2:0]  tick_a, tick_w, tick_s;
   logic [15:0] el_a;
   logic [2:0]  el_w, el_s;
   logic        ovf_a, ovf_w, ovf_s;

   timebase_gen #(.DIV_W(17), .DEFAULT_DIV(4), .NUM_CASC(2), .CASC_RATIO(3),
                  .CNT_W(16), .SATURATE(1'b0)) dut_a (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .div_load(div_load),
      .div_value(div_value), .load_pending(pend_a), .tick(tick_a),
      .elapsed(el_a), .ovf(ovf_a));

   timebase_gen #(.DIV_W(17), .DEFAULT_DIV(4), .NUM_CASC(2), .CASC_RATIO(3),
                  .CNT_W(3), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .div_load(div_load),
      .div_value(div_value), .load_pending(pend_w), .tick(tick_w),
      .elapsed(el_w), .ovf(ovf_w));

   timebase_gen #(.DIV_W(17), .DEFAULT_DIV(4), .NUM_CASC(2), .CASC_RATIO(3),
                  .CNT_W(3), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .div_load(div_load),
      .div_value(div_value), .load_pending(pend_s), .tick(tick_s),
      .elapsed(el_s), .ovf(ovf_s));

   typedef struct packed {
      logic [2:0]  tick;
      logic        pend;
      logic [15:0] el_a;
      logic        ovf_a;
      logic [2:0]  el_w;
      logic        ovf_w;
      logic [2:0]  el_s;
      logic        ovf_s;
   } exp_t;

   exp_t exp_q[$];

   int n_chk = 0;
   int n_err = 0;

   // Reference model: prescaler/divisor handling plus a total base-tick count
   // since reset/clr from which cascade ticks and counter values are derived.
   int m_pre, m_div, m_shadow, m_nb;
   bit m_pend;

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0d exp=%0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int clampv(input int v);
      return (v < 2) ? 2 : v;
   endfunction

   task automatic model_reset();
      m_pre = 0; m_div = 4; m_shadow = 0; m_pend = 0; m_nb = 0;
   endtask

   // One clock: model the edge from the inputs currently driven, push the
   // expectation, let the DUT take the edge, then pop and compare.
   task automatic cyc();
      exp_t e;
      exp_t g;
      bit   s0;
      e = '0;
      if (clr) begin
         m_pre = 0;
         if (m_pend) begin
            m_div  = m_shadow;
            m_pend = 0;
         end
         m_nb = 0;
      end else begin
         s0 = en && (m_pre == m_div - 1);
         if (en) m_pre = s0 ? 0 : m_pre + 1;
         if (s0) begin
            m_nb++;
            e.tick[0] = 1'b1;
            e.tick[1] = (m_nb % 3 == 0);
            e.tick[2] = (m_nb % 9 == 0);
            if (div_load) begin
               m_div = clampv(int'(div_value));
               m_pend = 0;
            end else if (m_pend) begin
               m_div = m_shadow;
               m_pend = 0;
            end
         end else if (div_load) begin
            m_shadow = clampv(int'(div_value));
            m_pend = 1;
         end
      end
      e.pend  = m_pend;
      e.el_a  = 16'(m_nb % 65536);
      e.ovf_a = (m_nb >= 65536);
      e.el_w  = 3'(m_nb % 8);
      e.ovf_w = (m_nb >= 8);
      e.el_s  = (m_nb > 7) ? 3'd7 : 3'(m_nb);
      e.ovf_s = (m_nb >= 8);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      g = exp_q.pop_front();
      chk("sb_tick_a", tick_a, g.tick);
      chk("sb_tick_w", tick_w, g.tick);
      chk("sb_tick_s", tick_s, g.tick);
      chk("sb_pend_a", pend_a, g.pend);
      chk("sb_pend_w", pend_w, g.pend);
      chk("sb_pend_s", pend_s, g.pend);
      chk("sb_el_a",   el_a,   g.el_a);
      chk("sb_ovf_a",  ovf_a,  g.ovf_a);
      chk("sb_el_w",   el_w,   g.el_w);
      chk("sb_ovf_w",  ovf_w,  g.ovf_w);
      chk("sb_el_s",   el_s,   g.el_s);
      chk("sb_ovf_s",  ovf_s,  g.ovf_s);
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!tick_a[0] && n < 100);
      if (!tick_a[0]) chk("tick_timeout", 0, 1);
   endtask

   task automatic load(input int v);
      div_load  = 1'b1;
      div_value = 17'(v);
      cyc();
      div_load  = 1'b0;
   endtask

   int n;
   int nb0;

   initial begin
      clk = 0; rst = 1; en = 1; clr = 0; div_load = 0; div_value = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tick", tick_a, 0);
      chk("rst_el", el_a, 0);
      chk("rst_pend", pend_a, 0);
      chk("rst_ovf", ovf_a, 0);
      rst = 0;

      // Default divisor 4, ratio 3: tick[2] at cycle 36 with everything.
      repeat (36) cyc();
      chk("c36_tick", tick_a, 3'b111);
      chk("c36_el", el_a, 9);

      // Load 6 at prescaler=1; current period still 4.
      cyc();
      load(6);
      chk("ld6_pend", pend_a, 1);
      wait_tick(n);
      chk("ld6_old_period", 2 + n, 4);
      chk("ld6_pend_clr", pend_a, 0);
      wait_tick(n); chk("ld6_period", n, 6);
      wait_tick(n); chk("ld6_period2", n, 6);

      // Load coincident with the wrap: applied at once, never pending.
      repeat (5) cyc();
      load(4);
      chk("coinc_tick", tick_a[0], 1);
      chk("coinc_pend", pend_a, 0);
      wait_tick(n); chk("coinc_period", n, 4);

      // Back-to-back loads while pending: last one wins.
      load(5);
      load(7);
      chk("b2b_pend", pend_a, 1);
      wait_tick(n); chk("b2b_old_period", 2 + n, 4);
      wait_tick(n); chk("b2b_period", n, 7);

      load(4);
      wait_tick(n);
      wait_tick(n); chk("reload4_period", n, 4);

      // Pause at prescaler=2 for 10 cycles.
      repeat (2) cyc();
      nb0 = m_nb;
      en = 0;
      repeat (10) begin
         cyc();
         chk("pause_tick", tick_a, 0);
      end
      chk("pause_el", el_a, nb0);
      en = 1;
      wait_tick(n); chk("resume_gap", n, 2);

      // Clamp of 0 and 1 to 2.
      load(0);
      wait_tick(n);
      wait_tick(n); chk("clamp0_period", n, 2);
      load(1);
      wait_tick(n);
      wait_tick(n); chk("clamp1_period", n, 2);

      // clr with pending load, ovf set and a same-cycle div_load.
      load(3);
      chk("preclr_pend", pend_a, 1);
      chk("preclr_el_s", el_s, 7);
      chk("preclr_ovf_s", ovf_s, 1);
      clr = 1; div_load = 1; div_value = 17'd9;
      cyc();
      clr = 0; div_load = 0;
      chk("clr_el_s", el_s, 0);
      chk("clr_ovf_s", ovf_s, 0);
      chk("clr_tick", tick_a, 0);
      chk("clr_pend", pend_a, 0);
      wait_tick(n); chk("clr_period", n, 3);

      // 3-bit counters: wrap vs saturate.
      repeat (6) wait_tick(n);
      chk("w7_el", el_w, 7);
      chk("s7_el", el_s, 7);
      wait_tick(n);
      chk("w8_el", el_w, 0);
      chk("w8_ovf", ovf_w, 1);
      chk("s8_el", el_s, 7);
      chk("s8_ovf", ovf_s, 1);

      // Async reset mid-period with a pending load.
      load(9);
      cyc();
      #2;
      rst = 1;
      #1;
      chk("arst_tick", tick_a, 0);
      chk("arst_el", el_a, 0);
      chk("arst_pend", pend_a, 0);
      chk("arst_ovf_w", ovf_w, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
      wait_tick(n); chk("arst_period", n, 4);
      wait_tick(n); chk("arst_period2", n, 4);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
